// File: rtl/wrapper_corr_wta.sv
// rtl/wrapper_corr_wta.sv - disparity correlation bank with sequential winner-take-all
module wrapper_corr_wta #(
  parameter int DATA_W   = 8,
  parameter int NUM_DISP = 11,
  parameter int IDX_W    = 4,
  parameter int CORR_W   = 2*DATA_W+1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [DATA_W-1:0]          d_l_1,
  input  logic [DATA_W-1:0]          d_l_2,
  input  logic [DATA_W-1:0]          d_r_1,
  input  logic [DATA_W-1:0]          d_r_2,
  output logic [NUM_DISP*CORR_W-1:0] corr_out,
  output logic                       corr_vld,
  output logic [IDX_W-1:0]           best_disp,
  output logic [CORR_W-1:0]          best_corr,
  output logic                       best_vld,
  output logic                       busy,
  output logic                       overrun
);

  localparam int PW = 2*DATA_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DISP-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  logic [DATA_W-1:0] l_re [NUM_DISP];
  logic [DATA_W-1:0] l_im [NUM_DISP];
  logic [DATA_W-1:0] r_re, r_im;
  logic [PW-1:0]     p_re [NUM_DISP];
  logic [PW-1:0]     p_im [NUM_DISP];
  logic              wen_d1, wen_d2;
  logic [NUM_DISP*CORR_W-1:0] sum_w;

  state_t            state;
  logic [CORR_W-1:0] snap [NUM_DISP];
  logic [IDX_W-1:0]  idx, run_disp;
  logic [CORR_W-1:0] run_best, cur_val, new_best;
  logic [IDX_W-1:0]  new_disp;
  logic              take;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NUM_DISP; d++) begin
        l_re[d] <= '0;
        l_im[d] <= '0;
      end
      r_re <= '0;
      r_im <= '0;
    end else if (wen) begin
      l_re[0] <= d_l_1;
      l_im[0] <= d_l_2;
      for (int d = 1; d < NUM_DISP; d++) begin
        l_re[d] <= l_re[d-1];
        l_im[d] <= l_im[d-1];
      end
      r_re <= d_r_1;
      r_im <= d_r_2;
    end
  end

  // Products run freely; only the delayed write-valid commits them to corr_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NUM_DISP; d++) begin
        p_re[d] <= '0;
        p_im[d] <= '0;
      end
      wen_d1 <= 1'b0;
      wen_d2 <= 1'b0;
    end else begin
      for (int d = 0; d < NUM_DISP; d++) begin
        p_re[d] <= PW'(l_re[d]) * PW'(r_re);
        p_im[d] <= PW'(l_im[d]) * PW'(r_im);
      end
      wen_d1 <= wen;
      wen_d2 <= wen_d1;
    end
  end

  always_comb begin
    sum_w = '0;
    for (int d = 0; d < NUM_DISP; d++)
      sum_w[d*CORR_W +: CORR_W] = CORR_W'(p_re[d]) + CORR_W'(p_im[d]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_out <= '0;
      corr_vld <= 1'b0;
    end else begin
      corr_vld <= wen_d2;
      if (wen_d2) corr_out <= sum_w;
    end
  end

  // Strict compare keeps the lowest index on ties; idx 0 seeds the running best.
  always_comb begin
    cur_val  = snap[idx];
    take     = (idx == '0) || (cur_val > run_best);
    new_best = take ? cur_val : run_best;
    new_disp = take ? idx : run_disp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int d = 0; d < NUM_DISP; d++) snap[d] <= '0;
      idx       <= '0;
      run_disp  <= '0;
      run_best  <= '0;
      best_disp <= '0;
      best_corr <= '0;
      best_vld  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (corr_vld && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          best_vld <= 1'b0;
          if (corr_vld) begin
            for (int d = 0; d < NUM_DISP; d++) snap[d] <= corr_out[d*CORR_W +: CORR_W];
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (idx == LAST) begin
            best_disp <= new_disp;
            best_corr <= new_best;
            best_vld  <= 1'b1;
            state     <= DONE;
          end else begin
            run_best <= new_best;
            run_disp <= new_disp;
            idx      <= idx + 1'b1;
          end
        end
        DONE: begin
          best_vld <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_wrapper_corr_wta.sv
// tb/tb_wrapper_corr_wta.sv - scoreboard bench for wrapper_corr_wta
module tb_wrapper_corr_wta;
  localparam int DW = 8;
  localparam int ND = 11;
  localparam int IW = 4;
  localparam int CW = 2*DW+1;

  logic clk = 1'b0;
  logic rst, wen;
  logic [DW-1:0] d_l_1, d_l_2, d_r_1, d_r_2;
  logic [ND*CW-1:0] corr_out;
  logic corr_vld, best_vld, busy, overrun;
  logic [IW-1:0] best_disp;
  logic [CW-1:0] best_corr;

  wrapper_corr_wta #(.DATA_W(DW), .NUM_DISP(ND), .IDX_W(IW), .CORR_W(CW)) dut (
    .clk(clk), .rst(rst), .wen(wen),
    .d_l_1(d_l_1), .d_l_2(d_l_2), .d_r_1(d_r_1), .d_r_2(d_r_2),
    .corr_out(corr_out), .corr_vld(corr_vld),
    .best_disp(best_disp), .best_corr(best_corr), .best_vld(best_vld),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_best = 0;

  int ml_re [ND];
  int ml_im [ND];
  int mr_re, mr_im;
  logic [ND*CW-1:0] corr_q [$];
  int best_d_q [$];
  int best_c_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (corr_vld === 1'b1) begin
      if (corr_q.size() == 0) chk("corr_vld_unexpected", 1, 0);
      else begin
        logic [ND*CW-1:0] e;
        e = corr_q.pop_front();
        for (int d = 0; d < ND; d++)
          chk($sformatf("corr_d%0d", d), 64'(corr_out[d*CW +: CW]), 64'(e[d*CW +: CW]));
      end
    end
    if (best_vld === 1'b1) begin
      n_best++;
      if (best_d_q.size() == 0) chk("best_vld_unexpected", 1, 0);
      else begin
        chk("best_disp", 64'(best_disp), 64'(best_d_q.pop_front()));
        chk("best_corr", 64'(best_corr), 64'(best_c_q.pop_front()));
      end
    end
  end

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin ml_re[d] = 0; ml_im[d] = 0; end
    mr_re = 0; mr_im = 0;
  endtask

  task automatic do_reset();
    chk("corr_q_empty_before_rst", 64'(corr_q.size()), 0);
    chk("best_q_empty_before_rst", 64'(best_d_q.size()), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; wen = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; wen is sampled at the next edge.
  task automatic send(input int l1, input int l2, input int r1, input int r2, input bit acc);
    logic [ND*CW-1:0] bank;
    int bd, bc, v;
    d_l_1 = DW'(l1); d_l_2 = DW'(l2); d_r_1 = DW'(r1); d_r_2 = DW'(r2);
    wen = 1'b1;
    @(posedge clk);
    for (int d = ND-1; d > 0; d--) begin ml_re[d] = ml_re[d-1]; ml_im[d] = ml_im[d-1]; end
    ml_re[0] = l1; ml_im[0] = l2; mr_re = r1; mr_im = r2;
    bd = 0; bc = 0;
    for (int d = 0; d < ND; d++) begin
      v = ml_re[d]*mr_re + ml_im[d]*mr_im;
      bank[d*CW +: CW] = CW'(v);
      if (d == 0 || v > bc) begin bd = d; bc = v; end
    end
    corr_q.push_back(bank);
    if (acc) begin best_d_q.push_back(bd); best_c_q.push_back(bc); end
    #1 wen = 1'b0;
  endtask

  initial begin
    int i, nb0;
    model_clear();
    rst = 1'b1; wen = 1'b1;
    d_l_1 = 8'd9; d_l_2 = 8'd7; d_r_1 = 8'd5; d_r_2 = 8'd3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; wen = 1'b0;
    @(negedge clk);
    chk("rst_corr_out", 64'(corr_out != '0), 0);
    chk("rst_corr_vld", 64'(corr_vld), 0);
    chk("rst_best_disp", 64'(best_disp), 0);
    chk("rst_best_corr", 64'(best_corr), 0);
    chk("rst_best_vld", 64'(best_vld), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_overrun", 64'(overrun), 0);
    @(posedge clk); #1;

    // latency: single sample
    send(10, 3, 4, 5, 1'b1);
    @(negedge clk); chk("lat_k", 64'(corr_vld), 0);
    @(negedge clk); chk("lat_k1", 64'(corr_vld), 0);
    @(negedge clk); chk("lat_k2", 64'(corr_vld), 1);
    chk("lat_corr0", 64'(corr_out[0 +: CW]), 55);
    chk("lat_corr_rest", 64'(corr_out[ND*CW-1:CW] != '0), 0);
    @(negedge clk); chk("lat_k3", 64'(corr_vld), 0);
    @(posedge clk); #1;
    idle(16);

    // disparity detection at 3
    do_reset();
    for (int s = 0; s <= 8; s++) begin
      send((s == 5) ? 200 : 0, 0, (s == 8) ? 200 : 0, 0, 1'b1);
      if (s < 8) idle(15);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("disp_corr_vld", 64'(corr_vld), 1);
    chk("disp_corr3", 64'(corr_out[3*CW +: CW]), 40000);
    for (i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (best_vld) break;
    end
    chk("disp_best_latency", 64'(i), 12);
    chk("disp_best_disp", 64'(best_disp), 3);
    chk("disp_best_corr", 64'(best_corr), 40000);
    @(posedge clk); #1;
    idle(4);

    // ties: zero inputs, then full scale
    do_reset();
    send(0, 0, 0, 0, 1'b1);
    idle(16);
    chk("zero_best_disp", 64'(best_disp), 0);
    chk("zero_best_corr", 64'(best_corr), 0);
    for (int s = 0; s < ND; s++) begin
      send(255, 255, 255, 255, 1'b1);
      idle(12);
    end
    idle(4);
    chk("full_corr_last", 64'(corr_out[(ND-1)*CW +: CW]), 130050);
    chk("full_best_disp", 64'(best_disp), 0);
    chk("full_best_corr", 64'(best_corr), 130050);

    // overrun with four back-to-back writes
    do_reset();
    nb0 = n_best;
    send(1, 2, 3, 4, 1'b1);
    send(5, 6, 7, 8, 1'b0);
    send(9, 10, 11, 12, 1'b0);
    send(13, 14, 15, 16, 1'b0);
    idle(20);
    chk("ovr_set", 64'(overrun), 1);
    chk("ovr_one_best", 64'(n_best - nb0), 1);
    idle(10);
    chk("ovr_sticky", 64'(overrun), 1);
    do_reset();
    @(negedge clk);
    chk("ovr_cleared", 64'(overrun), 0);
    @(posedge clk); #1;

    // reset mid-scan
    nb0 = n_best;
    send(7, 1, 2, 2, 1'b0);
    idle(7);
    chk("mid_busy_before", 64'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("mid_busy_after", 64'(busy), 0);
    chk("mid_best_disp", 64'(best_disp), 0);
    chk("mid_best_corr", 64'(best_corr), 0);
    @(posedge clk); #1;
    idle(20);
    chk("mid_no_best", 64'(n_best - nb0), 0);
    send(3, 4, 6, 9, 1'b1);
    idle(20);
    chk("mid_recover_best", 64'(n_best - nb0), 1);

    chk("final_corr_q_empty", 64'(corr_q.size()), 0);
    chk("final_best_q_empty", 64'(best_d_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
